komut_cozucu_kuyruklu: RTL

- Parametrised, buffered successor to the single-cycle RV32I instruction decoder.
- Instructions enter through a valid/ready input port into a DEPTH-entry FIFO.
- Each instruction is decoded into a registered output stage with its own valid/ready handshake.
- Adds format classification, per-format field masking, stricter illegal-encoding detection and a saturating error counter.
- Sits between instruction fetch and the register-file/ALU issue logic.

---
 rtl/komut_cozucu_kuyruklu.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/komut_cozucu_kuyruklu.sv
// Buffered RV32I decoder: FIFO in front of a registered decode stage.
// Optional flush input enabled by defining KOMUT_BOSALT_EN.
module komut_cozucu_kuyruklu #(
   parameter int DEPTH   = 4,
   parameter int SAYAC_W = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
`ifdef KOMUT_BOSALT_EN
   input  logic                         bosalt,
`endif
   input  logic                         giris_gecerli,
   output logic                         giris_hazir,
   input  logic [31:0]                  komut,
   output logic                         cikis_gecerli,
   input  logic                         cikis_hazir,
   output logic [6:0]                   opcode,
   output logic [3:0]                   aluop,
   output logic [4:0]                   rs1,
   output logic [4:0]                   rs2,
   output logic [4:0]                   rd,
   output logic [31:0]                  imm,
   output logic [2:0]                   format,
   output logic                         hata,
   output logic [$clog2(DEPTH+1)-1:0]   doluluk,
   output logic [SAYAC_W-1:0]           hata_sayisi
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] DOLU = CW'(DEPTH);

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_IALU  = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;

   localparam logic [2:0] F_R   = 3'd0;
   localparam logic [2:0] F_I   = 3'd1;
   localparam logic [2:0] F_S   = 3'd2;
   localparam logic [2:0] F_B   = 3'd3;
   localparam logic [2:0] F_U   = 3'd4;
   localparam logic [2:0] F_J   = 3'd5;
   localparam logic [2:0] F_ILL = 3'd7;

   logic [31:0]         mem_q [DEPTH];
   logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]       sayi_q, sayi_d;

   logic                gecerli_q;
   logic [6:0]          opcode_q;
   logic [3:0]          aluop_q;
   logic [4:0]          rs1_q, rs2_q, rd_q;
   logic [31:0]         imm_q;
   logic [2:0]          format_q;
   logic                hata_q;
   logic [SAYAC_W-1:0]  hata_sayisi_q, hata_sayisi_d;

   logic                bosalt_w;
   logic                yaz, yukle, teslim;

   logic [31:0]         bas;
   logic [6:0]          op;
   logic [2:0]          f3;
   logic [6:0]          f7;
   logic [2:0]          format_d;
   logic                hata_d;
   logic [3:0]          aluop_d;
   logic [4:0]          rs1_d, rs2_d, rd_d;
   logic [31:0]         imm_d;

`ifdef KOMUT_BOSALT_EN
   assign bosalt_w = bosalt;
`else
   assign bosalt_w = 1'b0;
`endif

   assign giris_hazir = (sayi_q != DOLU) && !bosalt_w;
   assign yaz         = giris_gecerli && giris_hazir;
   assign yukle       = (sayi_q != '0) && (!gecerli_q || cikis_hazir)
                        && !bosalt_w;
   assign teslim      = gecerli_q && cikis_hazir;

   always_comb begin
      wr_ptr_d = yaz   ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = yukle ? rd_ptr_q + 1'b1 : rd_ptr_q;
      sayi_d   = sayi_q;
      unique case ({yaz, yukle})
         2'b10:   sayi_d = sayi_q + CW'(1);
         2'b01:   sayi_d = sayi_q - CW'(1);
         default: sayi_d = sayi_q;
      endcase
      if (bosalt_w) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         sayi_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (yaz) mem_q[wr_ptr_q] <= komut;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         sayi_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         sayi_q   <= sayi_d;
      end
   end

   // Decode the FIFO head so the stage can load it in one edge.
   always_comb begin
      bas      = mem_q[rd_ptr_q];
      op       = bas[6:0];
      f3       = bas[14:12];
      f7       = bas[31:25];
      format_d = F_ILL;
      hata_d   = 1'b1;
      aluop_d  = '0;
      unique case (1'b1)
         op == OP_R: begin
            format_d = F_R;
            hata_d   = !((f7 == 7'h00) ||
                         ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101))));
            aluop_d  = {bas[30], f3};
         end
         op == OP_IALU: begin
            format_d = F_I;
            hata_d   = ((f3 == 3'b001) && (f7 != 7'h00)) ||
                       ((f3 == 3'b101) && (f7 != 7'h00) && (f7 != 7'h20));
            aluop_d  = {(f3 == 3'b101) ? bas[30] : 1'b0, f3};
         end
         op == OP_LOAD: begin
            format_d = F_I;
            hata_d   = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
         end
         op == OP_JALR: begin
            format_d = F_I;
            hata_d   = (f3 != 3'b000);
         end
         op == OP_STORE: begin
            format_d = F_S;
            hata_d   = (f3 >= 3'b011);
         end
         op == OP_BR: begin
            format_d = F_B;
            hata_d   = (f3 == 3'b010) || (f3 == 3'b011);
         end
         (op == OP_LUI) || (op == OP_AUIPC): begin
            format_d = F_U;
            hata_d   = 1'b0;
         end
         op == OP_JAL: begin
            format_d = F_J;
            hata_d   = 1'b0;
         end
         default: begin
            format_d = F_ILL;
            hata_d   = 1'b1;
         end
      endcase

      rs1_d = ((format_d == F_U) || (format_d == F_J)) ? 5'd0 : bas[19:15];
      rs2_d = ((format_d == F_R) || (format_d == F_S) || (format_d == F_B))
              ? bas[24:20] : 5'd0;
      rd_d  = ((format_d == F_S) || (format_d == F_B)) ? 5'd0 : bas[11:7];

      unique case (format_d)
         F_I:     imm_d = {{20{bas[31]}}, bas[31:20]};
         F_S:     imm_d = {{20{bas[31]}}, bas[31:25], bas[11:7]};
         F_B:     imm_d = {{19{bas[31]}}, bas[31], bas[7],
                           bas[30:25], bas[11:8], 1'b0};
         F_U:     imm_d = {bas[31:12], 12'd0};
         F_J:     imm_d = {{11{bas[31]}}, bas[31], bas[19:12],
                           bas[20], bas[30:21], 1'b0};
         default: imm_d = '0;
      endcase

      if (hata_d) begin
         format_d = F_ILL;
         aluop_d  = '0;
         rs1_d    = '0;
         rs2_d    = '0;
         rd_d     = '0;
         imm_d    = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gecerli_q <= 1'b0;
         opcode_q  <= '0;
         aluop_q   <= '0;
         rs1_q     <= '0;
         rs2_q     <= '0;
         rd_q      <= '0;
         imm_q     <= '0;
         format_q  <= '0;
         hata_q    <= 1'b0;
      end else if (bosalt_w) begin
         gecerli_q <= 1'b0;
      end else if (yukle) begin
         gecerli_q <= 1'b1;
         opcode_q  <= op;
         aluop_q   <= aluop_d;
         rs1_q     <= rs1_d;
         rs2_q     <= rs2_d;
         rd_q      <= rd_d;
         imm_q     <= imm_d;
         format_q  <= format_d;
         hata_q    <= hata_d;
      end else if (teslim) begin
         gecerli_q <= 1'b0;
      end
   end

   // Count illegal words as the consumer takes them; stick at all-ones.
   always_comb begin
      hata_sayisi_d = hata_sayisi_q;
      if (teslim && hata_q && !(&hata_sayisi_q))
         hata_sayisi_d = hata_sayisi_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) hata_sayisi_q <= '0;
      else        hata_sayisi_q <= hata_sayisi_d;
   end

   assign cikis_gecerli = gecerli_q;
   assign opcode        = opcode_q;
   assign aluop         = aluop_q;
   assign rs1           = rs1_q;
   assign rs2           = rs2_q;
   assign rd            = rd_q;
   assign imm           = imm_q;
   assign format        = format_q;
   assign hata          = hata_q;
   assign doluluk       = sayi_q;
   assign hata_sayisi   = hata_sayisi_q;

endmodule
